// File: rtl/karatsuba_mult_stream.sv
// Streaming Karatsuba multiplier with valid/ready flow control, a per-operation signed mode and a sideband tag.
// There are seven register stages: S0 inputs, S1-S3 partial products, S4 carry-save, S5-S6 split adder.
module karatsuba_mult_stream #(
  parameter int IN_WIDTH  = 64,
  parameter int TAG_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_WIDTH-1:0]     a,
  input  logic [IN_WIDTH-1:0]     b,
  input  logic                    in_signed,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*IN_WIDTH-1:0]   o,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  localparam int W = IN_WIDTH / 2;
  localparam int P = 2 * IN_WIDTH;

  logic en;

  // Valid bits for S0..S6. Bit 6 is out_valid.
  logic [6:0]           vld_q;
  logic [P-1:0]         o_q, o_d;
  logic [TAG_WIDTH-1:0] out_tag_q;

  // S0 registers
  logic [IN_WIDTH-1:0]  a_q, b_q;
  logic                 sgn_q;
  logic [W:0]           sa_q, sb_q;
  logic [W:0]           sa_d, sb_d;

  // S1..S3 partial products (index 0 = S1) and the negated signed correction
  logic [IN_WIDTH-1:0]  pphh_q [3];
  logic [IN_WIDTH-1:0]  ppll_q [3];
  logic [IN_WIDTH+1:0]  pphl_q [3];
  logic [IN_WIDTH-1:0]  neg_q  [3];
  logic [IN_WIDTH-1:0]  pphh_d, ppll_d, neg_d;
  logic [IN_WIDTH+1:0]  pphl_d;

  // S4 carry-save pair
  logic [P-1:0]         sum_q, cry_q, sum_d, cry_d;

  // S5 low half result plus the untouched upper halves
  logic [IN_WIDTH-1:0]  lo_q, shi_q, chi_q;
  logic                 c_q;
  logic [IN_WIDTH:0]    lo_d;

  // Tags for S0..S5. The S6 tag is out_tag_q.
  logic [TAG_WIDTH-1:0] tag_q [6];

  assign en        = ~vld_q[6] | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[6];
  assign o         = o_q;
  assign out_tag   = out_tag_q;

  // S0 combinational half-sums
  always_comb begin
    sa_d = {1'b0, a[IN_WIDTH-1:W]} + {1'b0, a[W-1:0]};
    sb_d = {1'b0, b[IN_WIDTH-1:W]} + {1'b0, b[W-1:0]};
  end

  // S1 partial products and the signed correction, both taken from S0
  always_comb begin
    logic [IN_WIDTH-1:0] ca, cb;
    pphh_d = {{W{1'b0}}, a_q[IN_WIDTH-1:W]} * {{W{1'b0}}, b_q[IN_WIDTH-1:W]};
    ppll_d = {{W{1'b0}}, a_q[W-1:0]} * {{W{1'b0}}, b_q[W-1:0]};
    pphl_d = {{(W+1){1'b0}}, sa_q} * {{(W+1){1'b0}}, sb_q};
    ca     = (sgn_q & a_q[IN_WIDTH-1]) ? b_q : '0;
    cb     = (sgn_q & b_q[IN_WIDTH-1]) ? a_q : '0;
    // Only the low IN_WIDTH bits of the correction matter because it lands at bit IN_WIDTH.
    neg_d  = -(ca + cb);
  end

  // S4: 3:2 compression of {pphh,ppll}, the middle term and the correction
  always_comb begin
    logic [IN_WIDTH+1:0] mid;
    logic [P-1:0]        x, y, z;
    mid   = pphl_q[2] - {2'b00, pphh_q[2]} - {2'b00, ppll_q[2]};
    x     = {pphh_q[2], ppll_q[2]};
    y     = {{(IN_WIDTH-2){1'b0}}, mid} << W;
    z     = {neg_q[2], {IN_WIDTH{1'b0}}};
    sum_d = x ^ y ^ z;
    cry_d = ((x & y) | (x & z) | (y & z)) << 1;
  end

  always_comb begin
    lo_d = {1'b0, sum_q[IN_WIDTH-1:0]} + {1'b0, cry_q[IN_WIDTH-1:0]};
    o_d  = {shi_q + chi_q + {{(IN_WIDTH-1){1'b0}}, c_q}, lo_q};
  end

  // Control and output registers. These are the only ones cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q     <= '0;
      o_q       <= '0;
      out_tag_q <= '0;
    end else if (en) begin
      vld_q     <= {vld_q[5:0], in_valid};
      o_q       <= o_d;
      out_tag_q <= tag_q[5];
    end
  end

  // Datapath registers. The whole pipe advances together on en, bubbles included.
  always_ff @(posedge clk) begin
    if (en) begin
      a_q       <= a;
      b_q       <= b;
      sgn_q     <= in_signed;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      tag_q[0]  <= in_tag;
      pphh_q[0] <= pphh_d;
      ppll_q[0] <= ppll_d;
      pphl_q[0] <= pphl_d;
      neg_q[0]  <= neg_d;
      for (int i = 1; i < 3; i++) begin
        pphh_q[i] <= pphh_q[i-1];
        ppll_q[i] <= ppll_q[i-1];
        pphl_q[i] <= pphl_q[i-1];
        neg_q[i]  <= neg_q[i-1];
      end
      for (int i = 1; i < 6; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
      sum_q <= sum_d;
      cry_q <= cry_d;
      lo_q  <= lo_d[IN_WIDTH-1:0];
      c_q   <= lo_d[IN_WIDTH];
      shi_q <= sum_q[P-1:IN_WIDTH];
      chi_q <= cry_q[P-1:IN_WIDTH];
    end
  end

endmodule

// File: tb/tb_karatsuba_mult_stream.sv
// Scoreboard bench for karatsuba_mult_stream. Expected products come from plain wide multiplication
// of sign- or zero-extended operands. Latency is checked against the accept-edge count.
module tb_karatsuba_mult_stream;
  localparam int IW = 64;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [IW-1:0]   a, b;
  logic            in_signed;
  logic [TW-1:0]   in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [2*IW-1:0] o;
  logic [TW-1:0]   out_tag;

  karatsuba_mult_stream #(.IN_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .o(o), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] exp;
    logic [TW-1:0] tag;
    int acc;
    bit lat;
  } item_t;

  item_t sbq[$];
  item_t mon_it;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit lat_mode;

  always @(posedge clk) cyc++;

  function automatic logic [127:0] ref_prod(input logic [63:0] x, input logic [63:0] y, input bit s);
    logic [127:0] xe, ye;
    xe = s ? {{64{x[63]}}, x} : {64'b0, x};
    ye = s ? {{64{y[63]}}, y} : {64'b0, y};
    return xe * ye;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic send_exp(input logic [63:0] x, input logic [63:0] y, input bit s,
                          input logic [TW-1:0] t, input logic [127:0] e);
    int w;
    item_t it;
    a = x; b = y; in_signed = s; in_tag = t; in_valid = 1'b1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", {127'b0, in_ready}, 128'd1);
    end else begin
      it.exp = e; it.tag = t; it.acc = cyc + 1; it.lat = lat_mode;
      sbq.push_back(it);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [63:0] x, input logic [63:0] y, input bit s, input logic [TW-1:0] t);
    send_exp(x, y, s, t, ref_prod(x, y, s));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 100) begin
      w++;
      @(posedge clk);
    end
    #1;
    chk("drain_left", sbq.size(), 0);
  endtask

  // Monitor: pops one expected result per output transfer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output actual tag=%0d o=%h required=none", out_tag, o);
      end else begin
        mon_it = sbq.pop_front();
        $display("txn tag=%0d o=%h latency=%0d", out_tag, o, cyc - mon_it.acc);
        chk("product", o, mon_it.exp);
        chk("tag", {124'b0, out_tag}, {124'b0, mon_it.tag});
        if (mon_it.lat) chk("latency", 128'(cyc - mon_it.acc), 128'd6);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0]  snap_o;
    logic [TW-1:0] snap_t;
    logic [TW-1:0] tg;
    logic [63:0]   x, y;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; in_signed = 1'b0; in_tag = '0;
    lat_mode = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_out_valid", {127'b0, out_valid}, 128'd0);
    chk("reset_o", o, 128'd0);
    chk("reset_out_tag", {124'b0, out_tag}, 128'd0);
    chk("reset_in_ready", {127'b0, in_ready}, 128'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-derived products
    send_exp(64'hFF, 64'hFF, 1'b0, 4'd3, 128'hFE01);
    send_exp(64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd4, 128'h80);
    send_exp(64'h80, 64'hFF, 1'b0, 4'd5, 128'h7F80);
    send_exp(64'hFFFF_FFFF_FFFF_FF80, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 4'd6, 128'h4000);
    send_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd7,
             128'hFFFFFFFFFFFFFFFE_0000000000000001);
    send_exp(64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd8, 128'h0);
    send_exp(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 4'd9, 128'h1 << 126);
    send_exp(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd10, 128'h1);
    send_exp(64'h8000_0000_0000_0000, 64'h1, 1'b1, 4'd11, 128'hFFFFFFFFFFFFFFFF_8000000000000000);

    // Back-to-back random stream
    tg = '0;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0: x = '1;
        1: x = 64'h8000_0000_0000_0000;
        default: x = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 7))
        0: y = '1;
        1: y = '0;
        default: y = {$urandom, $urandom};
      endcase
      send(x, y, 1'($urandom_range(0, 1)), tg);
      tg = tg + 1'b1;
    end
    drain();

    // Backpressure: six in flight, five stalled edges
    lat_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 4'(i));
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; a = {$urandom, $urandom}; b = {$urandom, $urandom}; in_tag = 4'hF;
    @(negedge clk);
    snap_o = o; snap_t = out_tag;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", {127'b0, in_ready}, 128'd0);
      chk("stall_out_valid", {127'b0, out_valid}, 128'd1);
      chk("stall_o", o, snap_o);
      chk("stall_tag", {124'b0, out_tag}, {124'b0, snap_t});
      if (i < 4) @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    // Reset with three operations in flight
    lat_mode = 1'b1;
    for (int i = 0; i < 3; i++) send({$urandom, $urandom}, {$urandom, $urandom}, 1'b0, 4'(i));
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_o", o, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_rst_idle", {127'b0, out_valid}, 128'd0);
    end
    @(posedge clk); #1;
    send_exp(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 4'hA,
             ref_prod(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/karatsuba_mult_stream.md
# karatsuba_mult_stream

Streaming, parametrised Karatsuba multiplier for the arithmetic library. It is the flow-controlled successor to the fixed 3-tick-multiplier Karatsuba block. It adds:
- a valid/ready handshake with full-pipeline stall;
- a per-operation signed/unsigned mode;
- a sideband tag that travels with each operand pair;
- an asynchronous active-low reset.

It sits between operand producers and consumers that can apply backpressure, such as modular-reduction and MAC datapaths.

## Interface
- IN_WIDTH, 64, operand width; must be even and ≥ 4; WORD_WIDTH = IN_WIDTH/2.
- TAG_WIDTH, 4, width of the sideband tag carried alongside each operation.
- clk  in  1  rising-edge clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset. Assertion is asynchronous; release must be synchronous to clk.
- in_valid  in  1  operand pair presented on a, b, in_signed, in_tag.
- in_ready  out  1  block accepts this cycle; combinational: in_ready = ~out_valid | out_ready.
- a  in  IN_WIDTH  multiplicand.
- b  in  IN_WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- in_tag  in  TAG_WIDTH  opaque tag, returned unchanged with the result.
- out_valid  out  1  result valid on o and out_tag.
- out_ready  in  1  consumer accepts this cycle.
- o  out  2*IN_WIDTH  product; full width, no truncation.
- out_tag  out  TAG_WIDTH  tag of the operation on o.

## Operation
- Transfer on input when in_valid & in_ready at a rising edge. Transfer on output when out_valid & out_ready.
- Global pipeline enable: en = ~out_valid | out_ready. When en=0 every stage, including valid bits, tag and signed flag, holds.
- Bubbles do not collapse. An empty stage still advances only when en=1.
- Operand split: a = {a_h, a_l}, b = {b_h, b_l}, with each half WORD_WIDTH wide.
- Three partial products:
  - pphh = a_h·b_h, width IN_WIDTH;
  - ppll = a_l·b_l, width IN_WIDTH;
  - pphl = (a_h+a_l)·(b_h+b_l), with (WORD_WIDTH+1)-bit sums and a 2·WORD_WIDTH+2-bit product.
- Unsigned product: U = pphh<<IN_WIDTH + (pphl − pphh − ppll)<<WORD_WIDTH + ppll. The middle term is never negative, so no wrap occurs before the final sum.
- Signed mode: o = U − (a[MSB] ? b : 0)<<IN_WIDTH − (b[MSB] ? a : 0)<<IN_WIDTH, taken mod 2^(2·IN_WIDTH). This is the exact two's-complement product. The correction is computed from stage-0 registers and folded into the compression stage.
- Unsigned mode: o = U exactly.
- Pipeline stages:
  - S0: input registers and half-sums;
  - S1–S3: partial-product multipliers, 3 ticks each, with all three aligned;
  - S4: carry-save compression of pphh, ppll, pphl and the signed correction;
  - S5–S6: two-cycle split carry-propagate adder; the S6 register drives o.
- Results leave in acceptance order. out_tag always pairs with its own product.

## Timing
- Reset (rst_n=0): all stage valid bits, out_valid, o and out_tag clear to 0 immediately and asynchronously. Internal data registers need no reset.
- in_ready is 1 during and after reset.
- Latency: an operation accepted at edge k appears with out_valid=1 after edge k+6, provided en=1 at every edge in between.
- Each edge with en=0 delays that result by one cycle.
- Throughput: one operation per cycle with out_ready held at 1.
- While out_valid=1 & out_ready=0:
  - o, out_tag and out_valid are held stable;
  - in_ready=0, and no input is accepted.
- Simultaneous events:
  - out_ready rising while in_valid=1 accepts a new input the same cycle, because in_ready follows out_ready combinationally.
  - in_valid=0 while en=1 inserts a bubble. out_valid=0 for that slot six cycles later.
- Reset mid-operation: all in-flight operations are discarded. No out_valid may assert until six edges after the first post-reset acceptance.
- The in_ready path is combinational from out_ready. Upstream logic must not make in_valid depend on in_ready.

## Test plan
- Unsigned basic, IN_WIDTH=8: a=0xFF, b=0xFF, in_signed=0, tag=3 accepted at edge 0 → out_valid after edge 6, o=0xFE01, out_tag=3.
- Signed mode, IN_WIDTH=8:
  - a=0x80, b=0xFF, signed → o=0x0080;
  - same operands, unsigned → o=0x7F80;
  - a=b=0x80, signed → o=0x4000.
- Corners, IN_WIDTH=64:
  - a=b=2^64−1, unsigned → o=0xFFFFFFFFFFFFFFFE_0000000000000001;
  - a=0, b=2^64−1 → o=0;
  - a=b=2^63, signed → o=2^126.
- Streaming, IN_WIDTH=64: 200 random operands back-to-back with random in_signed, incrementing tags and out_ready=1 → 200 results in order, one per cycle, all matching the reference model.
- Backpressure: six operations in flight, out_ready=0 for 5 cycles → in_ready=0 and o/out_tag stable during the stall; afterwards all six delivered in order, with no loss and no duplicates.
- Reset mid-stream: drop rst_n with three operations in flight → out_valid=0 and o=0 immediately. After release, no out_valid until six edges after a new accepted input, which then returns its correct product.
